stream_demux: RTL and testbench

Parametrised, registered 1-to-NUM_CH stream demultiplexer with valid/ready handshake and packet-sticky channel selection. Successor to the team's combinational 8-way demux: generalised in data width and channel count, adds enable gating, backpressure, per-packet select latching and a drop counter for out-of-range selects. Sits between a single upstream producer and NUM_CH downstream consumers.

---
 rtl/stream_demux.sv | 124 ++++++++++++
 tb/tb_stream_demux.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/stream_demux.sv
// Registered 1-to-NUM_CH stream demultiplexer with a valid/ready handshake.
// The channel is latched per packet, and beats with an out-of-range select are dropped and counted.
module stream_demux #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 8,
    parameter int SEL_W  = $clog2(NUM_CH),
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_last,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_valid,
    output logic                     out_last,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic                     busy,
    output logic [CNT_W-1:0]         drop_cnt
);

    typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    cur_ch_q, cur_ch_d;
    logic                stg_valid_q, stg_valid_d;
    logic [SEL_W-1:0]    stg_ch_q, stg_ch_d;
    logic [DATA_W-1:0]   stg_data_q, stg_data_d;
    logic                stg_last_q, stg_last_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

    logic [NUM_CH-1:0]   stg_oh;
    logic                drain, free, accept, sel_ok;

    assign stg_oh = {{(NUM_CH-1){1'b0}}, 1'b1} << stg_ch_q;
    // Only the ready of the channel currently held in the stage matters.
    assign drain  = stg_valid_q && |(out_ready & stg_oh);
    assign free   = !stg_valid_q || drain;
    assign sel_ok = {1'b0, in_sel} < (SEL_W+1)'(NUM_CH);
    assign accept = in_valid && in_ready;

    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            if (state_q == DROP) in_ready = en;
            else                 in_ready = en && free;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_ch_d    = cur_ch_q;
        stg_valid_d = stg_valid_q;
        stg_ch_d    = stg_ch_q;
        stg_data_d  = stg_data_q;
        stg_last_d  = stg_last_q;
        drop_cnt_d  = drop_cnt_q;

        if (drain) stg_valid_d = 1'b0;

        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (sel_ok) begin
                        stg_valid_d = 1'b1;
                        stg_ch_d    = in_sel;
                        stg_data_d  = in_data;
                        stg_last_d  = in_last;
                        cur_ch_d    = in_sel;
                        if (!in_last) state_d = ROUTE;
                    end else begin
                        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
                        if (!in_last) state_d = DROP;
                    end
                end
                ROUTE: begin
                    stg_valid_d = 1'b1;
                    stg_ch_d    = cur_ch_q;
                    stg_data_d  = in_data;
                    stg_last_d  = in_last;
                    if (in_last) state_d = IDLE;
                end
                DROP: begin
                    if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
                    if (in_last) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_ch_q    <= '0;
            stg_valid_q <= 1'b0;
            stg_ch_q    <= '0;
            stg_data_q  <= '0;
            stg_last_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cur_ch_q    <= cur_ch_d;
            stg_valid_q <= stg_valid_d;
            stg_ch_q    <= stg_ch_d;
            stg_data_q  <= stg_data_d;
            stg_last_q  <= stg_last_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_valid = stg_valid_q ? stg_oh : '0;
    assign out_last  = stg_valid_q && stg_last_q;
    assign busy      = (state_q != IDLE);
    assign drop_cnt  = drop_cnt_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_out
        assign out_data[k*DATA_W +: DATA_W] = out_valid[k] ? stg_data_q : '0;
    end

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: an 8-channel instance (a_*) and a
// 6-channel instance with a 2-bit drop counter (b_*), both on one clock.
module tb_stream_demux;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_en, a_in_valid, a_in_ready, a_in_last, a_out_last, a_busy;
    logic [7:0]  a_in_data, a_out_valid, a_out_ready, a_drop_cnt;
    logic [2:0]  a_in_sel;
    logic [63:0] a_out_data;

    logic        b_en, b_in_valid, b_in_ready, b_in_last, b_out_last, b_busy;
    logic [7:0]  b_in_data;
    logic [5:0]  b_out_valid, b_out_ready;
    logic [2:0]  b_in_sel;
    logic [47:0] b_out_data;
    logic [1:0]  b_drop_cnt;

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_a;
    logic [47:0] exp_b;

    stream_demux u_a (
        .clk(clk), .rst_n(rst_n), .en(a_en), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .in_sel(a_in_sel), .in_last(a_in_last), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_last(a_out_last), .out_ready(a_out_ready),
        .busy(a_busy), .drop_cnt(a_drop_cnt)
    );

    stream_demux #(.DATA_W(8), .NUM_CH(6), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .en(b_en), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .in_sel(b_in_sel), .in_last(b_in_last), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_last(b_out_last), .out_ready(b_out_ready),
        .busy(b_busy), .drop_cnt(b_drop_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_en = 1'b1; a_in_valid = 1'b0; a_in_data = '0; a_in_sel = '0; a_in_last = 1'b0; a_out_ready = '1;
        b_en = 1'b1; b_in_valid = 1'b0; b_in_data = '0; b_in_sel = '0; b_in_last = 1'b0; b_out_ready = '1;
        tick(); tick();
        tests++; if (a_out_valid !== 8'h00) begin fails++; $display("FAIL reset_out_valid got %h exp 00", a_out_valid); end
        tests++; if (a_out_data !== 64'h0) begin fails++; $display("FAIL reset_out_data got %h exp 0", a_out_data); end
        tests++; if (a_out_last !== 1'b0 || a_busy !== 1'b0) begin fails++; $display("FAIL reset_last_busy got %b%b exp 00", a_out_last, a_busy); end
        tests++; if (a_drop_cnt !== 8'h00 || b_drop_cnt !== 2'b00) begin fails++; $display("FAIL reset_drop_cnt got %h/%h exp 0/0", a_drop_cnt, b_drop_cnt); end
        tests++; if (a_in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b exp 0", a_in_ready); end
        rst_n = 1'b1;
        #1;
        tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL idle_in_ready got %b exp 1", a_in_ready); end
    endtask

    task automatic test_single_beat();
        a_in_valid = 1'b1; a_in_sel = 3'd5; a_in_data = 8'hA5; a_in_last = 1'b1; a_out_ready = 8'hFF;
        tick();
        a_in_valid = 1'b0;
        exp_a = 64'hA5 << 40;
        tests++; if (a_out_valid !== 8'h20) begin fails++; $display("FAIL single_valid got %h exp 20", a_out_valid); end
        tests++; if (a_out_data !== exp_a) begin fails++; $display("FAIL single_data got %h exp %h", a_out_data, exp_a); end
        tests++; if (a_out_last !== 1'b1 || a_busy !== 1'b0) begin fails++; $display("FAIL single_last_busy got %b%b exp 10", a_out_last, a_busy); end
        tick();
        tests++; if (a_out_valid !== 8'h00) begin fails++; $display("FAIL single_drain got %h exp 00", a_out_valid); end
    endtask

    task automatic test_packet();
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin
            d = 8'h11 * 8'(i + 1);
            a_in_valid = 1'b1; a_in_data = d; a_in_sel = (i == 0) ? 3'd2 : 3'd7; a_in_last = (i == 3);
            tick();
            exp_a = 64'(d) << 16;
            tests++; if (a_out_valid !== 8'h04 || a_out_data !== exp_a) begin fails++; $display("FAIL packet_beat%0d got %h/%h exp 04/%h", i, a_out_valid, a_out_data, exp_a); end
            tests++; if (a_busy !== (i != 3) || a_out_last !== (i == 3)) begin fails++; $display("FAIL packet_busy_last%0d got %b%b exp %b%b", i, a_busy, a_out_last, i != 3, i == 3); end
        end
        a_in_valid = 1'b0;
        tick();
        tests++; if (a_out_valid !== 8'h00) begin fails++; $display("FAIL packet_drain got %h exp 00", a_out_valid); end
    endtask

    task automatic test_backpressure();
        a_out_ready = 8'h20;
        a_in_valid = 1'b1; a_in_sel = 3'd3; a_in_data = 8'h33; a_in_last = 1'b1;
        tick();
        a_in_sel = 3'd4; a_in_data = 8'h55;
        exp_a = 64'h33 << 24;
        for (int i = 0; i < 3; i++) begin
            tests++; if (a_in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready%0d got %b exp 0", i, a_in_ready); end
            tests++; if (a_out_valid !== 8'h08 || a_out_data !== exp_a) begin fails++; $display("FAIL bp_hold%0d got %h/%h exp 08/%h", i, a_out_valid, a_out_data, exp_a); end
            tick();
        end
        a_out_ready = 8'hFF;
        #1;
        tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL bp_resume_ready got %b exp 1", a_in_ready); end
        tick();
        a_in_valid = 1'b0;
        exp_a = 64'h55 << 32;
        tests++; if (a_out_valid !== 8'h10 || a_out_data !== exp_a) begin fails++; $display("FAIL bp_replace got %h/%h exp 10/%h", a_out_valid, a_out_data, exp_a); end
        tick();
        tests++; if (a_out_valid !== 8'h00) begin fails++; $display("FAIL bp_drain got %h exp 00", a_out_valid); end
    endtask

    task automatic test_drop();
        b_out_ready = 6'h3F;
        for (int i = 0; i < 3; i++) begin
            b_in_valid = 1'b1; b_in_sel = 3'd7; b_in_data = 8'hD0 + 8'(i); b_in_last = (i == 2);
            #1;
            tests++; if (b_in_ready !== 1'b1) begin fails++; $display("FAIL drop_ready%0d got %b exp 1", i, b_in_ready); end
            tick();
            tests++; if (b_out_valid !== 6'h00 || b_drop_cnt !== 2'(i + 1)) begin fails++; $display("FAIL drop_beat%0d got %h/%0d exp 00/%0d", i, b_out_valid, b_drop_cnt, i + 1); end
            tests++; if (b_busy !== (i != 2)) begin fails++; $display("FAIL drop_busy%0d got %b exp %b", i, b_busy, i != 2); end
        end
        b_in_valid = 1'b0;
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 2; i++) begin
            b_in_valid = 1'b1; b_in_sel = 3'd6; b_in_data = 8'hEE; b_in_last = 1'b1;
            tick();
            tests++; if (b_drop_cnt !== 2'd3 || b_out_valid !== 6'h00 || b_busy !== 1'b0) begin fails++; $display("FAIL sat%0d got %0d/%h/%b exp 3/00/0", i, b_drop_cnt, b_out_valid, b_busy); end
        end
        b_in_sel = 3'd5; b_in_data = 8'h5C;
        tick();
        b_in_valid = 1'b0;
        exp_b = 48'h5C << 40;
        tests++; if (b_out_valid !== 6'h20 || b_out_data !== exp_b) begin fails++; $display("FAIL top_channel got %h/%h exp 20/%h", b_out_valid, b_out_data, exp_b); end
    endtask

    task automatic test_enable_reset();
        a_out_ready = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            a_in_valid = 1'b1; a_in_sel = 3'd6; a_in_data = 8'h61 + 8'(i); a_in_last = 1'b0;
            tick();
        end
        a_en = 1'b0; a_in_data = 8'h63;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++; if (a_in_ready !== 1'b0 || a_busy !== 1'b1) begin fails++; $display("FAIL en_hold%0d got %b%b exp 01", i, a_in_ready, a_busy); end
            tick();
            tests++; if (a_out_valid !== 8'h00) begin fails++; $display("FAIL en_drain%0d got %h exp 00", i, a_out_valid); end
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        tests++; if (a_out_valid !== 8'h00 || a_out_data !== 64'h0 || a_busy !== 1'b0 || a_drop_cnt !== 8'h00) begin fails++; $display("FAIL midreset got %h/%h/%b/%h exp 0", a_out_valid, a_out_data, a_busy, a_drop_cnt); end
        a_en = 1'b1; a_in_valid = 1'b1; a_in_sel = 3'd1; a_in_data = 8'h77; a_in_last = 1'b1;
        tick();
        a_in_valid = 1'b0;
        exp_a = 64'h77 << 8;
        tests++; if (a_out_valid !== 8'h02 || a_out_data !== exp_a || a_busy !== 1'b0) begin fails++; $display("FAIL post_reset got %h/%h/%b exp 02/%h/0", a_out_valid, a_out_data, a_busy, exp_a); end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_packet();
        test_backpressure();
        test_drop();
        test_saturate();
        test_enable_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
